// File: rtl/pseudo_softmax_pkg.sv
// Shared types and defaults for the pseudo-softmax datapath.
// Pseudo-float: value = 2^exp * (1 + mant/2^MANT_WIDTH), unsigned exponent, no bias.
package pseudo_softmax_pkg;

    localparam int DEFAULT_EXP_WIDTH  = 9;
    localparam int DEFAULT_MANT_WIDTH = 8;

    localparam logic [DEFAULT_EXP_WIDTH-1:0] EXP_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } acc_state_t;

endpackage

// File: rtl/flp_align_add.sv
// Combinational pseudo-float adder: align, add, normalise, saturate.
// Truncates by default; define FLP_ROUND_EN for round-half-up at both right shifts.
module flp_align_add
    import pseudo_softmax_pkg::*;
#(
    parameter int EXP_WIDTH  = DEFAULT_EXP_WIDTH,
    parameter int MANT_WIDTH = DEFAULT_MANT_WIDTH
) (
    input  logic [EXP_WIDTH-1:0]  a_exp,
    input  logic [MANT_WIDTH-1:0] a_mant,
    input  logic [EXP_WIDTH-1:0]  b_exp,
    input  logic [MANT_WIDTH-1:0] b_mant,
    output logic [EXP_WIDTH-1:0]  s_exp,
    output logic [MANT_WIDTH-1:0] s_mant,
    output logic                  s_ovf
);

    localparam int SIG_W = MANT_WIDTH + 1;
    localparam logic [EXP_WIDTH-1:0] SHIFT_LIMIT = EXP_WIDTH'(MANT_WIDTH);
    localparam logic [EXP_WIDTH:0]   EXP_TOP     = {1'b0, {EXP_WIDTH{1'b1}}};

    logic                  a_larger;
    logic [EXP_WIDTH-1:0]  big_exp;
    logic [EXP_WIDTH-1:0]  diff;
    logic [SIG_W-1:0]      big_sig;
    logic [SIG_W-1:0]      small_sig;
    logic [SIG_W-1:0]      aligned;
    logic [SIG_W:0]        sum;
    logic [MANT_WIDTH-1:0] norm_mant;
    logic [1:0]            exp_bump;
    logic [EXP_WIDTH:0]    exp_wide;
`ifdef FLP_ROUND_EN
    logic [SIG_W-1:0]      rnd_mask;
    logic                  align_rnd;
    logic [SIG_W:0]        norm_rnd;
`endif

    always_comb begin
        a_larger  = (a_exp >= b_exp);
        big_exp   = a_larger ? a_exp : b_exp;
        diff      = a_larger ? (a_exp - b_exp) : (b_exp - a_exp);
        big_sig   = a_larger ? {1'b1, a_mant} : {1'b1, b_mant};
        small_sig = a_larger ? {1'b1, b_mant} : {1'b1, a_mant};
        aligned   = (diff > SHIFT_LIMIT) ? '0 : (small_sig >> diff);

`ifdef FLP_ROUND_EN
        // The last bit lost by alignment is the one at position diff-1.
        rnd_mask  = '0;
        align_rnd = 1'b0;
        norm_rnd  = '0;
        if ((diff != '0) && (diff <= SHIFT_LIMIT)) begin
            rnd_mask  = SIG_W'(1) << (diff - EXP_WIDTH'(1));
            align_rnd = |(small_sig & rnd_mask);
        end
        sum = {1'b0, big_sig} + {1'b0, aligned} + {{SIG_W{1'b0}}, align_rnd};
`else
        sum = {1'b0, big_sig} + {1'b0, aligned};
`endif

        norm_mant = sum[MANT_WIDTH-1:0];
        exp_bump  = 2'd0;
        if (sum[SIG_W]) begin
`ifdef FLP_ROUND_EN
            // Rounding can carry once more, giving exactly 2.0 -> mant 0, exponent +2.
            norm_rnd = {1'b0, sum[SIG_W:1]} + {{SIG_W{1'b0}}, sum[0]};
            if (norm_rnd[SIG_W]) begin
                norm_mant = norm_rnd[SIG_W-1:1];
                exp_bump  = 2'd2;
            end else begin
                norm_mant = norm_rnd[MANT_WIDTH-1:0];
                exp_bump  = 2'd1;
            end
`else
            norm_mant = sum[MANT_WIDTH:1];
            exp_bump  = 2'd1;
`endif
        end

        exp_wide = {1'b0, big_exp} + {{(EXP_WIDTH-1){1'b0}}, exp_bump};
        if (exp_wide > EXP_TOP) begin
            s_exp  = '1;
            s_mant = '1;
            s_ovf  = 1'b1;
        end else begin
            s_exp  = exp_wide[EXP_WIDTH-1:0];
            s_mant = norm_mant;
            s_ovf  = 1'b0;
        end
    end

endmodule

// File: rtl/flp_accumulator.sv
// Sums N_TERMS pseudo-float terms per frame into one denominator over valid/ready.
// Optional rounding in the adder is enabled with the FLP_ROUND_EN macro.
module flp_accumulator
    import pseudo_softmax_pkg::*;
#(
    parameter int EXP_WIDTH  = DEFAULT_EXP_WIDTH,
    parameter int MANT_WIDTH = DEFAULT_MANT_WIDTH,
    parameter int N_TERMS    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [EXP_WIDTH-1:0]  in_exp,
    input  logic [MANT_WIDTH-1:0] in_mant,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXP_WIDTH-1:0]  out_exp,
    output logic [MANT_WIDTH-1:0] out_mant,
    output logic                  out_ovf
);

    localparam int CNT_W = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(N_TERMS);

    acc_state_t            state_q, state_d;
    logic [CNT_W-1:0]      count_q;
    logic [EXP_WIDTH-1:0]  acc_exp_q;
    logic [MANT_WIDTH-1:0] acc_mant_q;
    logic                  ovf_q;

    logic                  term_accept;
    logic                  sum_accept;
    logic [EXP_WIDTH-1:0]  add_exp;
    logic [MANT_WIDTH-1:0] add_mant;
    logic                  add_ovf;

    flp_align_add #(
        .EXP_WIDTH  (EXP_WIDTH),
        .MANT_WIDTH (MANT_WIDTH)
    ) u_align_add (
        .a_exp  (acc_exp_q),
        .a_mant (acc_mant_q),
        .b_exp  (in_exp),
        .b_mant (in_mant),
        .s_exp  (add_exp),
        .s_mant (add_mant),
        .s_ovf  (add_ovf)
    );

    assign term_accept = in_valid & in_ready;
    assign sum_accept  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = (N_TERMS == 1) ? DONE : ACC;
                end
            end
            ACC: begin
                in_ready = 1'b1;
                if (in_valid && ((count_q + CNT_W'(1)) == LAST_COUNT)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The first term of a frame loads the accumulator; later terms go through the adder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            acc_exp_q  <= '0;
            acc_mant_q <= '0;
            ovf_q      <= 1'b0;
        end else if (sum_accept) begin
            count_q    <= '0;
            acc_exp_q  <= '0;
            acc_mant_q <= '0;
            ovf_q      <= 1'b0;
        end else if (term_accept) begin
            if (state_q == IDLE) begin
                count_q    <= CNT_W'(1);
                acc_exp_q  <= in_exp;
                acc_mant_q <= in_mant;
            end else begin
                count_q    <= count_q + CNT_W'(1);
                acc_exp_q  <= add_exp;
                acc_mant_q <= add_mant;
                ovf_q      <= ovf_q | add_ovf;
            end
        end
    end

    assign out_exp  = acc_exp_q;
    assign out_mant = acc_mant_q;
    assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_flp_accumulator.sv
// Directed bench for flp_accumulator (EXP_WIDTH=9, MANT_WIDTH=8, N_TERMS=4).
// Expected values are hand-computed; FLP_ROUND_EN selects the rounded expectation where it differs.
module tb_flp_accumulator;

    localparam int EW = 9;
    localparam int MW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [EW-1:0] in_exp = '0;
    logic [MW-1:0] in_mant = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [EW-1:0] out_exp;
    logic [MW-1:0] out_mant;
    logic          out_ovf;

    int checks = 0;
    int failures = 0;

    flp_accumulator #(
        .EXP_WIDTH  (EW),
        .MANT_WIDTH (MW),
        .N_TERMS    (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_exp   (out_exp),
        .out_mant  (out_mant),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Presents one term and holds it until the DUT takes it on a rising edge.
    task automatic apply_stimulus(input logic [EW-1:0] e, input logic [MW-1:0] m);
        int guard = 0;
        in_valid = 1'b1;
        in_exp   = e;
        in_mant  = m;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check_output("term_accept_timeout", 16'(in_ready), 16'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [EW-1:0] e0, input logic [MW-1:0] m0,
                              input logic [EW-1:0] e1, input logic [MW-1:0] m1,
                              input logic [EW-1:0] e2, input logic [MW-1:0] m2,
                              input logic [EW-1:0] e3, input logic [MW-1:0] m3);
        apply_stimulus(e0, m0);
        apply_stimulus(e1, m1);
        apply_stimulus(e2, m2);
        apply_stimulus(e3, m3);
    endtask

    // Checks the sum one cycle after the last term, then hands it off.
    task automatic check_sum(input string tag, input logic [EW-1:0] e, input logic [MW-1:0] m, input logic ovf);
        @(negedge clk);
        check_output({tag, "_valid"}, 16'(out_valid), 16'd1);
        check_output({tag, "_exp"}, 16'(out_exp), 16'(e));
        check_output({tag, "_mant"}, 16'(out_mant), 16'(m));
        check_output({tag, "_ovf"}, 16'(out_ovf), 16'(ovf));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #2;
        check_output("reset_in_ready", 16'(in_ready), 16'd1);
        check_output("reset_out_valid", 16'(out_valid), 16'd0);
        check_output("reset_out_exp", 16'(out_exp), 16'd0);
        check_output("reset_out_mant", 16'(out_mant), 16'd0);
        check_output("reset_out_ovf", 16'(out_ovf), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 8+8+8+8 = 32
        send_frame(9'd3, 8'h00, 9'd3, 8'h00, 9'd3, 8'h00, 9'd3, 8'h00);
        check_sum("t1", 9'd5, 8'h00, 1'b0);

        // 16+4+4+8 = 32
        send_frame(9'd4, 8'h00, 9'd2, 8'h00, 9'd2, 8'h00, 9'd3, 8'h00);
        check_sum("t2", 9'd5, 8'h00, 1'b0);

        // Tiny terms vanish when the exponent gap exceeds the fraction width
        send_frame(9'd20, 8'h00, 9'd0, 8'h00, 9'd0, 8'h00, 9'd0, 8'h00);
        check_sum("t3", 9'd20, 8'h00, 1'b0);

        send_frame(9'd511, 8'h80, 9'd511, 8'h80, 9'd511, 8'h80, 9'd511, 8'h80);
        check_sum("t4_sat", 9'd511, 8'hFF, 1'b1);
        send_frame(9'd3, 8'h00, 9'd3, 8'h00, 9'd3, 8'h00, 9'd3, 8'h00);
        check_sum("t4_clear", 9'd5, 8'h00, 1'b0);

        // 40 + 24 + 4 + 124 = 192 = 2^7 * 1.5
        send_frame(9'd5, 8'h40, 9'd4, 8'h80, 9'd2, 8'h00, 9'd6, 8'hF0);
        check_sum("t7_mixed", 9'd7, 8'h80, 1'b0);

        // Stall in DONE with a stray term offered; it must be ignored
        send_frame(9'd4, 8'h00, 9'd2, 8'h00, 9'd2, 8'h00, 9'd3, 8'h00);
        in_valid = 1'b1;
        in_exp   = 9'd100;
        in_mant  = 8'h55;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("t5_hold_valid", 16'(out_valid), 16'd1);
            check_output("t5_hold_in_ready", 16'(in_ready), 16'd0);
            check_output("t5_hold_exp", 16'(out_exp), 16'd5);
            check_output("t5_hold_mant", 16'(out_mant), 16'h00);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check_output("t5_in_ready_after", 16'(in_ready), 16'd1);
        check_output("t5_valid_after", 16'(out_valid), 16'd0);

        // out_ready while nothing is valid must not disturb the next frame
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send_frame(9'd3, 8'h00, 9'd3, 8'h00, 9'd3, 8'h00, 9'd3, 8'h00);
        check_sum("t5_b2b", 9'd5, 8'h00, 1'b0);

        // Abort mid-frame with reset
        apply_stimulus(9'd10, 8'h11);
        apply_stimulus(9'd10, 8'h22);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("t6_rst_in_ready", 16'(in_ready), 16'd1);
        check_output("t6_rst_exp", 16'(out_exp), 16'd0);
        check_output("t6_rst_valid", 16'(out_valid), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(9'd3, 8'h00, 9'd3, 8'h00, 9'd3, 8'h00, 9'd3, 8'h00);
        check_sum("t6_after_rst", 9'd5, 8'h00, 1'b0);

        // 2 + 1.00390625 + 1 + 1: rounding keeps the lost LSBs
        send_frame(9'd1, 8'h00, 9'd0, 8'h01, 9'd0, 8'h00, 9'd0, 8'h00);
`ifdef FLP_ROUND_EN
        check_sum("t6_round", 9'd2, 8'h41, 1'b0);
`else
        check_sum("t6_trunc", 9'd2, 8'h40, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
